// File: rtl/fifo_rd_agent_if.sv
// fifo_rd_agent_if: bundle of the FIFO read port plus the passive write-side tap.
//   r_en     : read enable, driven by the agent
//   empty    : FIFO empty flag
//   data_out : FIFO read data, valid the cycle after an accepted read
//   w_en     : FIFO write enable (observed only)
//   full     : FIFO full flag
// master = agent side, slave = FIFO / environment side.
interface fifo_rd_agent_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  r_en;
  logic                  empty;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  w_en;
  logic                  full;

  modport master (
    output r_en,
    input  empty,
    input  data_out,
    input  w_en,
    input  full
  );

  modport slave (
    input  r_en,
    output empty,
    output data_out,
    output w_en,
    output full
  );
endinterface

// File: rtl/fifo_rd_agent.sv
// fifo_rd_agent: drains a FIFO at a programmable minimum read interval, registers
// the read data into a one-cycle output strobe, and tracks FIFO occupancy plus
// an occupancy integral for off-block average-occupancy computation.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   fifo          : FIFO read port and write-side tap (master modport)
//   en_i          : agent enable
//   period_i      : minimum cycles between reads (0 behaves as 1)
//   out_valid_o   : one-cycle strobe qualifying out_data_o
//   out_data_o    : captured read data, held between strobes
//   rd_count_o    : accepted reads (saturating)
//   occ_level_o   : tracked FIFO occupancy, bounded to [0, DEPTH]
//   occ_sum_o     : sum of occupancy over enabled cycles (saturating)
//   cycle_count_o : enabled cycles (saturating)
//   wr_drop_o     : sticky flag, a write was attempted while full
module fifo_rd_agent #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PERIOD_W   = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  fifo_rd_agent_if.master              fifo,
  input  logic                         en_i,
  input  logic [PERIOD_W-1:0]          period_i,
  output logic                         out_valid_o,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic [CNT_W-1:0]             rd_count_o,
  output logic [$clog2(DEPTH+1)-1:0]   occ_level_o,
  output logic [CNT_W-1:0]             occ_sum_o,
  output logic [CNT_W-1:0]             cycle_count_o,
  output logic                         wr_drop_o
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                state_q,       state_d;
  logic [PERIOD_W-1:0]   cnt_q,         cnt_d;
  logic                  cap_q,         cap_d;
  logic                  out_valid_q,   out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,    out_data_d;
  logic [CNT_W-1:0]      rd_count_q,    rd_count_d;
  logic [OCC_W-1:0]      occ_q,         occ_d;
  logic [CNT_W-1:0]      occ_sum_q,     occ_sum_d;
  logic [CNT_W-1:0]      cycle_count_q, cycle_count_d;
  logic                  wr_drop_q,     wr_drop_d;

  logic                  push_c;
  logic                  pop_c;
  logic                  pending_c;
  logic                  r_en_c;
  logic [PERIOD_W-1:0]   reload_c;

  // Saturating add: clamps at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Reload value max(period,1)-1, so period 0 and 1 both allow back-to-back reads.
  assign reload_c  = (period_i == '0) ? '0 : period_i - PERIOD_W'(1);
  assign pending_c = (cnt_q == '0);

  // Read request is combinational so a stalled read fires the first cycle
  // empty deasserts, and drops in the same cycle en falls.
  assign r_en_c    = en_i & (state_q == ST_RUN) & pending_c & ~fifo.empty;
  assign pop_c     = r_en_c & ~fifo.empty;
  assign push_c    = fifo.w_en & ~fifo.full;

  assign fifo.r_en = r_en_c;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      cap_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      rd_count_q    <= '0;
      occ_q         <= '0;
      occ_sum_q     <= '0;
      cycle_count_q <= '0;
      wr_drop_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cap_q         <= cap_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      rd_count_q    <= rd_count_d;
      occ_q         <= occ_d;
      occ_sum_q     <= occ_sum_d;
      cycle_count_q <= cycle_count_d;
      wr_drop_q     <= wr_drop_d;
    end
  end

  // Next-state logic for the FSM, rate counter, capture pipe and statistics.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cap_d         = pop_c;
    out_valid_d   = cap_q;
    out_data_d    = out_data_q;
    rd_count_d    = sat_add(rd_count_q, CNT_W'(pop_c));
    occ_d         = occ_q;
    occ_sum_d     = occ_sum_q;
    cycle_count_d = cycle_count_q;
    wr_drop_d     = wr_drop_q | (fifo.w_en & fifo.full);

    unique case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          state_d = ST_RUN;
          cnt_d   = reload_c;
        end
      end
      ST_RUN: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (pop_c) begin
          cnt_d = reload_c;
        end else if (!pending_c) begin
          cnt_d = cnt_q - PERIOD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // FIFO data_out is valid the cycle after the pop, so capture one cycle late.
    if (cap_q) begin
      out_data_d = fifo.data_out;
    end

    // Occupancy follows both ports regardless of en; simultaneous push+pop nets out.
    if (push_c && !pop_c && (occ_q != OCC_W'(DEPTH))) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop_c && !push_c && (occ_q != '0)) begin
      occ_d = occ_q - OCC_W'(1);
    end

    // Integral uses the pre-update occupancy of each enabled cycle.
    if (en_i) begin
      occ_sum_d     = sat_add(occ_sum_q, CNT_W'(occ_q));
      cycle_count_d = sat_add(cycle_count_q, CNT_W'(1));
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign rd_count_o    = rd_count_q;
  assign occ_level_o   = occ_q;
  assign occ_sum_o     = occ_sum_q;
  assign cycle_count_o = cycle_count_q;
  assign wr_drop_o     = wr_drop_q;

endmodule

// File: tb/tb_fifo_rd_agent.sv
// Bench for fifo_rd_agent: a queue-based FIFO model answers the agent's reads,
// a reference model predicts read timing and statistics from the rate rules,
// and a scoreboard matches each popped word against the output strobe.
module tb_fifo_rd_agent;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned DEPTH      = 8;
  localparam int unsigned PERIOD_W   = 4;
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned OCC_W      = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst, en, w_en;
  logic [PERIOD_W-1:0]   period;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  out_valid, wr_drop;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CNT_W-1:0]      rd_count, occ_sum, cycle_count;
  logic [OCC_W-1:0]      occ_level;

  logic                  f_empty = 1'b1;
  logic                  f_full  = 1'b0;
  logic [DATA_WIDTH-1:0] f_dout  = '0;

  fifo_rd_agent_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();
  assign bus.empty    = f_empty;
  assign bus.full     = f_full;
  assign bus.data_out = f_dout;
  assign bus.w_en     = w_en;

  fifo_rd_agent #(
    .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .PERIOD_W(PERIOD_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .fifo(bus), .en_i(en), .period_i(period),
    .out_valid_o(out_valid), .out_data_o(out_data), .rd_count_o(rd_count),
    .occ_level_o(occ_level), .occ_sum_o(occ_sum), .cycle_count_o(cycle_count),
    .wr_drop_o(wr_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model state
  typedef struct { logic [DATA_WIDTH-1:0] data; int due; } exp_t;
  exp_t                  exp_q[$];
  logic [DATA_WIDTH-1:0] fq[$];
  int     cyc = 0;
  bit     m_run = 1'b0;
  int     m_since = 0, m_need = 1;
  longint m_rd = 0, m_sum = 0, m_cyc = 0;
  bit     m_drop = 1'b0;

  function automatic int peff(input logic [PERIOD_W-1:0] p);
    return (p == '0) ? 1 : int'(p);
  endfunction

  // FIFO model plus reference update at each rising edge.
  always @(posedge clk) begin : model
    bit   pop, push, was_full;
    int   occ_now;
    exp_t e;
    occ_now  = fq.size();
    was_full = (occ_now >= int'(DEPTH));
    pop      = (bus.r_en === 1'b1) && (occ_now != 0);
    push     = (w_en === 1'b1) && !was_full;
    if (rst) begin
      fq.delete();
      exp_q.delete();
      m_run = 1'b0; m_rd = 0; m_sum = 0; m_cyc = 0; m_drop = 1'b0;
      f_empty <= 1'b1;
      f_full  <= 1'b0;
    end else begin
      if (en) begin
        m_sum += occ_now;
        m_cyc++;
      end
      if (pop) begin
        e.data = fq.pop_front();
        e.due  = cyc + 2;
        exp_q.push_back(e);
        f_dout <= e.data;
        m_rd++;
      end
      if (push) fq.push_back(wdata);
      if (w_en && was_full) m_drop = 1'b1;
      if (!m_run) begin
        if (en) begin m_run = 1'b1; m_need = peff(period); m_since = 1; end
      end else if (!en) begin
        m_run = 1'b0;
      end else if (pop) begin
        m_need = peff(period); m_since = 1;
      end else begin
        m_since++;
      end
      f_empty <= (fq.size() == 0);
      f_full  <= (fq.size() == int'(DEPTH));
    end
    cyc++;
  end

  // Per-cycle comparison of read request and statistics against the model.
  always @(negedge clk) begin
    #1;
    if (chk_on) begin
      check("r_en", 64'(bus.r_en),
            64'(en && m_run && (fq.size() != 0) && (m_since >= m_need)));
      check("occ_level", 64'(occ_level), 64'(fq.size()));
      check("rd_count", 64'(rd_count), 64'(m_rd));
      check("occ_sum", 64'(occ_sum), 64'(m_sum));
      check("cycle_count", 64'(cycle_count), 64'(m_cyc));
      check("wr_drop", 64'(wr_drop), 64'(m_drop));
    end
  end

  // Scoreboard monitor: match each output strobe to the oldest pop.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (chk_on) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 64'(out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(e.data));
          check("out_latency", 64'(cyc), 64'(e.due));
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check("missing_out_valid", 64'(out_valid), 64'(1));
      end
    end
  end

  task automatic wait_ren(input int maxc, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk); #1;
      if (bus.r_en === 1'b1) begin ok = 1'b1; break; end
    end
    check(name, 64'(ok), 64'(1));
  endtask

  task automatic rst_pulse();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    int     hits[$];
    int     occ_before;
    bit     both;
    longint snap;
    rst = 1'b1; en = 1'b0; w_en = 1'b0; period = '0; wdata = '0;
    @(negedge clk); @(negedge clk); #1;
    chk_on = 1'b1;
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    rst = 1'b0;

    // Fixed rate: preload 0x11..0x15, period 3.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); w_en = 1'b1; wdata = DATA_WIDTH'(8'h11 + i);
    end
    @(negedge clk); w_en = 1'b0; period = PERIOD_W'(3); en = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk); #1;
      if (bus.r_en === 1'b1) hits.push_back(i);
    end
    check("fixed_hit_count", 64'(hits.size()), 64'(5));
    for (int k = 0; k < 5 && k < hits.size(); k++)
      check("fixed_hit_cycle", 64'(hits[k]), 64'(3 * (k + 1)));
    repeat (3) @(negedge clk);
    #1;
    check("fixed_rd_count", 64'(rd_count), 64'(5));
    check("fixed_occ_level", 64'(occ_level), 64'(0));

    // Empty stall at period 2.
    @(negedge clk); en = 1'b0;
    @(negedge clk); period = PERIOD_W'(2); en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      check("stall_r_en_low", 64'(bus.r_en), 64'(0));
    end
    @(negedge clk); w_en = 1'b1; wdata = 8'hA5;
    @(negedge clk); wdata = 8'hA6; #1;
    check("stall_first_read", 64'(bus.r_en), 64'(1));
    @(negedge clk); w_en = 1'b0; #1;
    check("stall_reload_wait", 64'(bus.r_en), 64'(0));
    @(negedge clk); #1;
    check("stall_second_read", 64'(bus.r_en), 64'(1));
    @(negedge clk); en = 1'b0;
    repeat (3) @(negedge clk);

    // Occupancy: writes on even cycles, reads at period 3, 60 enabled cycles.
    rst_pulse();
    period = PERIOD_W'(3);
    both = 1'b0; occ_before = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      en = 1'b1; w_en = (i % 2 == 0); wdata = DATA_WIDTH'($urandom);
      #1;
      if (both) check("push_pop_hold", 64'(occ_level), 64'(occ_before));
      check("occ_bound", 64'(occ_level <= OCC_W'(DEPTH)), 64'(1));
      occ_before = fq.size();
      both = (bus.r_en === 1'b1) && w_en && (fq.size() < int'(DEPTH)) && (fq.size() != 0);
    end
    @(negedge clk); en = 1'b0; w_en = 1'b0; #1;
    if (both) check("push_pop_hold", 64'(occ_level), 64'(occ_before));
    check("occ_cycle_count", 64'(cycle_count), 64'(60));
    check("occ_sum_total", 64'(occ_sum), 64'(m_sum));
    repeat (3) @(negedge clk);

    // Full/drop: 10 writes into 8 entries with the agent disabled.
    rst_pulse();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); w_en = 1'b1; wdata = DATA_WIDTH'(8'h40 + i);
    end
    @(negedge clk); w_en = 1'b0; #1;
    check("drop_occ_sat", 64'(occ_level), 64'(DEPTH));
    check("drop_flag", 64'(wr_drop), 64'(1));
    check("drop_cycle_count", 64'(cycle_count), 64'(0));
    repeat (5) @(negedge clk);
    #1;
    check("drop_sticky", 64'(wr_drop), 64'(1));

    // Enable drop right after a pop: the capture still completes.
    @(negedge clk); period = PERIOD_W'(1); en = 1'b1;
    wait_ren(10, "endrop_wait_r_en");
    @(negedge clk); en = 1'b0; #1;
    snap = m_cyc;
    @(negedge clk); #1;
    check("endrop_strobe", 64'(out_valid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("endrop_no_r_en", 64'(bus.r_en), 64'(0));
    end
    check("endrop_cycle_freeze", 64'(cycle_count), 64'(snap));

    // Reset mid-run with a pop in flight.
    @(negedge clk); en = 1'b1;
    wait_ren(10, "rst_wait_r_en");
    @(negedge clk); rst = 1'b1; en = 1'b0;
    @(negedge clk); #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'(0));
    check("rst_mid_out_data", 64'(out_data), 64'(0));
    check("rst_mid_rd_count", 64'(rd_count), 64'(0));
    check("rst_mid_occ_level", 64'(occ_level), 64'(0));
    check("rst_mid_occ_sum", 64'(occ_sum), 64'(0));
    check("rst_mid_cycle_count", 64'(cycle_count), 64'(0));
    check("rst_mid_wr_drop", 64'(wr_drop), 64'(0));
    check("rst_mid_r_en", 64'(bus.r_en), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("rst_no_strobe", 64'(out_valid), 64'(0));
    end

    // Randomized traffic with enable and period changes.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 9) == 0) period = PERIOD_W'($urandom_range(0, 5));
      w_en  = ($urandom_range(0, 2) != 0);
      wdata = DATA_WIDTH'($urandom);
    end
    @(negedge clk); en = 1'b0; w_en = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_rd_agent.md
# fifo_rd_agent

Reader-side agent for the team's `fifo` block: it drains the FIFO at a programmable rate, captures read data into a registered output stream, and observes both FIFO ports to keep a running occupancy level and occupancy integral for average-occupancy measurement. It sits on the FIFO read port, with a passive tap on the write enable and `full`. It is the synthesizable counterpart to the bench-driven read stimulus.

## Interface
- `DATA_WIDTH`, 8, FIFO data width
- `DEPTH`, 8, FIFO depth in entries (bounds `occ_level`)
- `PERIOD_W`, 4, width of `period`
- `CNT_W`, 32, width of `occ_sum` / `cycle_count` / `rd_count`
- `clk` in 1: single clock; all logic is on its rising edge
- `rst` in 1: synchronous, active-high reset
- `en` in 1: agent enable
- `period` in PERIOD_W: minimum cycles between reads; 0 is treated as 1
- `w_en` in 1: FIFO write enable (observed only)
- `full` in 1: FIFO full
- `empty` in 1: FIFO empty
- `data_out` in DATA_WIDTH: FIFO read data; valid the cycle after an accepted read
- `r_en` out 1: FIFO read enable
- `out_valid` out 1: one-cycle strobe, `out_data` valid
- `out_data` out DATA_WIDTH: captured read data
- `rd_count` out CNT_W: accepted reads
- `occ_level` out $clog2(DEPTH+1): tracked FIFO occupancy
- `occ_sum` out CNT_W: sum of `occ_level` over enabled cycles
- `cycle_count` out CNT_W: enabled cycles
- `wr_drop` out 1: sticky; set when `w_en & full` is seen

## Operation
- `push = w_en & !full`; `pop = r_en & !empty`.
- **State IDLE** (`en`=0)
  - `r_en`=0.
  - Counters and accumulators hold.
  - `en`=1 moves to RUN, with the period counter loaded to `max(period,1)-1`.
- **State RUN**
  - The period counter decrements to 0 and then holds; `pending` = counter==0.
  - `r_en = pending & !empty`, combinational from registered `pending` and `empty`.
  - On `pop`, the counter reloads to `max(period,1)-1`. With `period`≤1 this allows a read on every non-empty cycle.
  - `pending` while `empty` stalls: `r_en` stays low, and the read fires on the first non-empty cycle.
  - `en`=0 returns to IDLE the next cycle. `r_en` drops immediately because it is gated by `en`.
- **Occupancy tracking**
  - `push & !pop` increments `occ_level`; `pop & !push` decrements it; both or neither leaves it unchanged.
  - `occ_level` saturates at 0 and DEPTH.
  - The occupancy update runs regardless of `en`.
- **Accumulators**
  - While `en`=1: `occ_sum += occ_level` (pre-update value) and `cycle_count += 1`.
  - `rd_count += pop`.
  - All three saturate at 2^CNT_W-1; they do not wrap.
- **Capture**
  - `pop` in cycle N sets a capture flag.
  - In N+1 `data_out` is registered into `out_data`; `out_valid`=1 in N+2 for one cycle.
  - `out_data` holds its value between strobes.
  - An in-flight capture completes even if `en` falls.
- **`wr_drop`**: sticky until `rst`.
- Average occupancy = `occ_sum`/`cycle_count`, computed off-block.

## Timing
- Reset values: `r_en`=0, `out_valid`=0, `out_data`=0, `rd_count`=0, `occ_level`=0, `occ_sum`=0, `cycle_count`=0, `wr_drop`=0, state IDLE, period counter 0, capture pipeline cleared.
- `rst` mid-operation discards any in-flight capture; no `out_valid` strobe follows.
- First `r_en` after `en` rises: earliest in cycle `max(period,1)` counting the first RUN cycle as 1, and only if `!empty`.
- Read-to-output latency: 2 cycles from the `r_en` cycle to the `out_valid` cycle. Throughput is 1 per cycle at `period`≤1.
- `occ_level` reflects pushes and pops accepted at the previous edge.
- `period` is sampled at each reload. A change takes effect at the next reload.

## Test plan
- **Reset**
  - Stimulus: hold `rst` 3 cycles mid-run, with a pop issued the cycle before `rst`.
  - Required: all outputs are 0 the cycle after; no `out_valid` follows.
- **Fixed rate**
  - Stimulus: `period`=3, FIFO preloaded with 5 entries 0x11..0x15, `en`=1.
  - Required: `r_en` in RUN cycles 3, 6, 9, 12, 15. `out_valid` 2 cycles after each, with data 0x11..0x15. `rd_count`=5 and `occ_level`=0 at the end.
- **Empty stall**
  - Stimulus: `period`=2 with the FIFO empty for 6 cycles, then one write.
  - Required: `r_en` stays 0 while empty. One `r_en` fires in the first cycle `empty`=0. The counter reloads only after that pop.
- **Occupancy**
  - Stimulus: writes on even cycles, reads on every third cycle, DEPTH=8, 60 enabled cycles.
  - Required:
    - `occ_level` never exceeds 8.
    - `cycle_count`=60.
    - `occ_sum` matches the bench model's per-cycle sum exactly.
    - A simultaneous push and pop leaves `occ_level` unchanged.
- **Full/drop**
  - Stimulus: `en`=0, 10 consecutive writes into the 8-deep FIFO.
  - Required: `occ_level` saturates at 8; `wr_drop`=1 and remains set; `cycle_count`=0.
- **Enable drop**
  - Stimulus: deassert `en` in the same cycle as a `pop`.
  - Required: that capture still strobes `out_valid` 2 cycles later; no further `r_en`; `occ_sum` and `cycle_count` freeze.
